// File: rtl/ca_rule_scheduler.sv
// Band/rule sequencer for the VGA cellular-automaton datapath: rule table, row/band tracking,
// seed-frame control and optional frame scrolling (enabled by defining CA_AUTOSCROLL_EN).
module ca_rule_scheduler #(
   parameter int unsigned BAND_ROWS  = 32,
   parameter int unsigned SCROLL_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       row_tick,
   input  logic       reseed,
   input  logic       pause,
   input  logic       cfg_wr,
   input  logic [2:0] cfg_addr,
   input  logic [7:0] cfg_data,
   output logic [7:0] rule,
   output logic [5:0] rule_color,
   output logic [2:0] band,
   output logic       seed_frame
);

   localparam int unsigned RowW = 3 + $clog2(BAND_ROWS);

   typedef enum logic [1:0] {StWait, StSeed, StRun} state_e;

   state_e          state_q, state_d;
   logic            seed_pend_q;
   logic [RowW-1:0] row_cnt_q, row_cnt_d;
   logic [RowW-1:0] frame_base;
   logic [7:0]      rule_tbl_q [8];
   logic [7:0]      rule_q;
   logic            enter_seed;

   // A reseed arriving with frame_start counts for this boundary.
   always_comb begin
      state_d = state_q;
      if (frame_start) begin
         case (state_q)
            StWait:        state_d = StSeed;
            StSeed, StRun: state_d = (seed_pend_q || reseed) ? StSeed : StRun;
            default:       state_d = StWait;
         endcase
      end
   end

   assign enter_seed = frame_start && (state_d == StSeed);

`ifdef CA_AUTOSCROLL_EN
   localparam int unsigned FcW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

   logic [FcW-1:0]  frame_cnt_q, frame_cnt_d;
   logic [RowW-1:0] base_ofs_q, base_ofs_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      base_ofs_d  = base_ofs_q;
      if (enter_seed) begin
         frame_cnt_d = '0;
         base_ofs_d  = '0;
      end else if (frame_start && (state_q == StRun) && !pause) begin
         if (frame_cnt_q == FcW'(SCROLL_DIV - 1)) begin
            frame_cnt_d = '0;
            base_ofs_d  = base_ofs_q + RowW'(1);
         end else begin
            frame_cnt_d = frame_cnt_q + FcW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         base_ofs_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         base_ofs_q  <= base_ofs_d;
      end
   end

   // The new frame starts from the offset updated on this same boundary.
   assign frame_base = base_ofs_d;
`else
   logic unused_pause;
   assign unused_pause = pause;
   assign frame_base   = '0;
`endif

   always_comb begin
      row_cnt_d = row_cnt_q;
      if (frame_start) begin
         row_cnt_d = enter_seed ? '0 : frame_base;
      end else if (row_tick) begin
         row_cnt_d = row_cnt_q + RowW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StWait;
         seed_pend_q <= 1'b1;
         row_cnt_q   <= '0;
         rule_q      <= 8'd30;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         rule_q    <= rule_tbl_q[band];
         if (enter_seed) begin
            seed_pend_q <= 1'b0;
         end else if (reseed) begin
            seed_pend_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rule_tbl_q[0] <= 8'd30;
         rule_tbl_q[1] <= 8'd110;
         rule_tbl_q[2] <= 8'd22;
         rule_tbl_q[3] <= 8'd73;
         rule_tbl_q[4] <= 8'd90;
         rule_tbl_q[5] <= 8'd146;
         rule_tbl_q[6] <= 8'd105;
         rule_tbl_q[7] <= 8'd102;
      end else if (cfg_wr) begin
         rule_tbl_q[cfg_addr] <= cfg_data;
      end
   end

   assign band       = row_cnt_q[RowW-1 -: 3];
   assign seed_frame = (state_q == StSeed);
   assign rule       = rule_q;
   assign rule_color = rule_q[6:1];

endmodule

// File: tb/tb_ca_rule_scheduler.sv
// Directed self-checking bench for ca_rule_scheduler (BAND_ROWS=32, SCROLL_DIV=4).
module tb_ca_rule_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       row_tick = 1'b0;
   logic       reseed = 1'b0;
   logic       pause = 1'b0;
   logic       cfg_wr = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic [7:0] rule;
   logic [5:0] rule_color;
   logic [2:0] band;
   logic       seed_frame;

   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;
   logic [7:0] exp_tbl [8];

   ca_rule_scheduler #(.BAND_ROWS(32), .SCROLL_DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_start(frame_start),
      .row_tick   (row_tick),
      .reseed     (reseed),
      .pause      (pause),
      .cfg_wr     (cfg_wr),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .rule       (rule),
      .rule_color (rule_color),
      .band       (band),
      .seed_frame (seed_frame)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic send_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         row_tick = 1'b1;
         step();
         row_tick = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      n_cmp++;
      if (rule !== 8'd30) begin
         n_fail++; $display("FAIL reset_rule: got %0d want 30", rule);
      end
      n_cmp++;
      if (rule_color !== 6'b001111) begin
         n_fail++; $display("FAIL reset_color: got %b want 001111", rule_color);
      end
      n_cmp++;
      if (band !== 3'd0 || seed_frame !== 1'b0) begin
         n_fail++; $display("FAIL reset_band_seed: got band %0d seed %b want 0 0", band, seed_frame);
      end
      send_frame();
      n_cmp++;
      if (seed_frame !== 1'b1) begin
         n_fail++; $display("FAIL first_seed_frame: got %b want 1", seed_frame);
      end
      step();
      n_cmp++;
      if (rule !== 8'd30) begin
         n_fail++; $display("FAIL first_frame_rule: got %0d want 30", rule);
      end
      send_frame();
      n_cmp++;
      if (seed_frame !== 1'b0) begin
         n_fail++; $display("FAIL second_frame_run: got %b want 0", seed_frame);
      end
   endtask

   task automatic test_band_walk();
      send_frame();
      send_ticks(31);
      n_cmp++;
      if (band !== 3'd0) begin
         n_fail++; $display("FAIL band_tick31: got %0d want 0", band);
      end
      send_ticks(1);
      n_cmp++;
      if (band !== 3'd1 || rule !== 8'd30) begin
         n_fail++; $display("FAIL band_tick32: got band %0d rule %0d want 1 30", band, rule);
      end
      step();
      n_cmp++;
      if (rule !== 8'd110 || rule_color !== 6'b110111) begin
         n_fail++; $display("FAIL band1_rule: got %0d/%b want 110/110111", rule, rule_color);
      end
   endtask

`ifdef CA_AUTOSCROLL_EN
   task automatic test_scroll();
      reseed = 1'b1;
      step();
      reseed = 1'b0;
      send_frame();
      send_frame();
      for (int i = 0; i < 3; i++) send_frame();
      n_cmp++;
      if (dut.base_ofs_q !== 8'd0) begin
         n_fail++; $display("FAIL scroll_pre: got %0d want 0", dut.base_ofs_q);
      end
      send_frame();
      n_cmp++;
      if (dut.row_cnt_q !== 8'd1 || dut.base_ofs_q !== 8'd1) begin
         n_fail++; $display("FAIL scroll_step: got row %0d base %0d want 1 1",
                            dut.row_cnt_q, dut.base_ofs_q);
      end
      for (int i = 0; i < 4 * 254; i++) send_frame();
      n_cmp++;
      if (dut.base_ofs_q !== 8'd255) begin
         n_fail++; $display("FAIL scroll_255: got %0d want 255", dut.base_ofs_q);
      end
      for (int i = 0; i < 4; i++) send_frame();
      n_cmp++;
      if (dut.base_ofs_q !== 8'd0) begin
         n_fail++; $display("FAIL scroll_wrap: got %0d want 0", dut.base_ofs_q);
      end
      for (int i = 0; i < 3; i++) send_frame();
      pause = 1'b1;
      for (int i = 0; i < 8; i++) send_frame();
      pause = 1'b0;
      n_cmp++;
      if (dut.base_ofs_q !== 8'd0) begin
         n_fail++; $display("FAIL scroll_pause: got %0d want 0", dut.base_ofs_q);
      end
      // One more unpaused frame completes the 4-frame period.
      send_frame();
      n_cmp++;
      if (dut.base_ofs_q !== 8'd1) begin
         n_fail++; $display("FAIL scroll_resume: got %0d want 1", dut.base_ofs_q);
      end
      for (int i = 0; i < 16; i++) send_frame();
      n_cmp++;
      if (dut.base_ofs_q !== 8'd5) begin
         n_fail++; $display("FAIL scroll_to5: got %0d want 5", dut.base_ofs_q);
      end
   endtask
`endif

   task automatic test_reseed();
      send_ticks(40);
      reseed = 1'b1;
      step();
      reseed = 1'b0;
      send_ticks(3);
      send_frame();
      n_cmp++;
      if (seed_frame !== 1'b1 || band !== 3'd0) begin
         n_fail++; $display("FAIL reseed_frame: got seed %b band %0d want 1 0", seed_frame, band);
      end
      send_frame();
      n_cmp++;
      if (seed_frame !== 1'b0) begin
         n_fail++; $display("FAIL reseed_back_run: got %b want 0", seed_frame);
      end
`ifdef CA_AUTOSCROLL_EN
      n_cmp++;
      if (dut.base_ofs_q !== 8'd0) begin
         n_fail++; $display("FAIL reseed_base: got %0d want 0", dut.base_ofs_q);
      end
`endif
      for (int i = 0; i < 3; i++) begin
         reseed = 1'b1;
         step();
         reseed = 1'b0;
         send_ticks(2);
      end
      send_frame();
      n_cmp++;
      if (seed_frame !== 1'b1) begin
         n_fail++; $display("FAIL multi_reseed_seed: got %b want 1", seed_frame);
      end
      send_frame();
      n_cmp++;
      if (seed_frame !== 1'b0) begin
         n_fail++; $display("FAIL multi_reseed_once: got %b want 0", seed_frame);
      end
   endtask

   task automatic test_live_rewrite();
      send_frame();
      send_ticks(64);
      step();
      n_cmp++;
      if (band !== 3'd2 || rule !== 8'd22) begin
         n_fail++; $display("FAIL rewrite_pre: got band %0d rule %0d want 2 22", band, rule);
      end
      cfg_wr   = 1'b1;
      cfg_addr = 3'd2;
      cfg_data = 8'd45;
      step();
      cfg_wr = 1'b0;
      n_cmp++;
      if (rule !== 8'd22) begin
         n_fail++; $display("FAIL rewrite_edge1: got %0d want 22", rule);
      end
      step();
      n_cmp++;
      if (rule !== 8'd45) begin
         n_fail++; $display("FAIL rewrite_edge2: got %0d want 45", rule);
      end
      exp_tbl[2] = 8'd45;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (dut.rule_tbl_q[i] !== exp_tbl[i]) begin
            n_fail++; $display("FAIL rewrite_tbl%0d: got %0d want %0d", i, dut.rule_tbl_q[i],
                               exp_tbl[i]);
         end
      end
      exp_tbl[2] = 8'd22;
   endtask

   task automatic test_collision_reset();
      send_frame();
      send_ticks(10);
      frame_start = 1'b1;
      row_tick    = 1'b1;
      step();
      frame_start = 1'b0;
      row_tick    = 1'b0;
      n_cmp++;
      if (dut.row_cnt_q !== 8'd0) begin
         n_fail++; $display("FAIL collision_row: got %0d want 0", dut.row_cnt_q);
      end
      reseed = 1'b1;
      step();
      reseed = 1'b0;
      send_frame();
      send_ticks(40);
      step();
      n_cmp++;
      if (seed_frame !== 1'b1 || rule !== 8'd110) begin
         n_fail++; $display("FAIL prereset: got seed %b rule %0d want 1 110", seed_frame, rule);
      end
      rst_n    = 1'b0;
      cfg_wr   = 1'b1;
      cfg_addr = 3'd0;
      cfg_data = 8'd99;
      step();
      rst_n  = 1'b1;
      cfg_wr = 1'b0;
      n_cmp++;
      if (rule !== 8'd30 || rule_color !== 6'b001111) begin
         n_fail++; $display("FAIL midreset_rule: got %0d/%b want 30/001111", rule, rule_color);
      end
      n_cmp++;
      if (band !== 3'd0 || seed_frame !== 1'b0) begin
         n_fail++; $display("FAIL midreset_band_seed: got %0d %b want 0 0", band, seed_frame);
      end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (dut.rule_tbl_q[i] !== exp_tbl[i]) begin
            n_fail++; $display("FAIL reset_tbl%0d: got %0d want %0d", i, dut.rule_tbl_q[i],
                               exp_tbl[i]);
         end
      end
   endtask

   initial begin
      exp_tbl[0] = 8'd30;
      exp_tbl[1] = 8'd110;
      exp_tbl[2] = 8'd22;
      exp_tbl[3] = 8'd73;
      exp_tbl[4] = 8'd90;
      exp_tbl[5] = 8'd146;
      exp_tbl[6] = 8'd105;
      exp_tbl[7] = 8'd102;
      test_reset();
      test_band_walk();
`ifdef CA_AUTOSCROLL_EN
      test_scroll();
`endif
      test_reseed();
      test_live_rewrite();
      test_collision_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
